// File: rtl/fpga_bus_pkg.sv
// Shared definitions for the 16-node serial bus: field widths, CRC-4
// polynomial, frame length, mode encoding and receiver FSM states.
package fpga_bus_pkg;

  localparam int unsigned ADDR_W     = 4;
  localparam int unsigned DATA_W     = 64;
  localparam int unsigned CRC_W      = 4;
  localparam int unsigned MOD_W      = 2;
  localparam logic [3:0]  CRC_POLY   = 4'b0011;  // x^4 + x + 1, x^4 term implicit
  localparam int unsigned FRAME_BITS = 1 + 2 * ADDR_W + MOD_W + DATA_W + CRC_W;

  typedef enum logic [1:0] {
    MOD_UNICAST = 2'b00,
    MOD_BCAST   = 2'b01,
    MOD_RSV0    = 2'b10,
    MOD_RSV1    = 2'b11
  } mod_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_CRC_RX
  } rx_state_e;

  // 16-bit increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/crc4_serial.sv
// Serial CRC-4 (x^4+x+1, init 0), one message bit per enabled clock.
// Shared between the bus transmitter and receiver.
// Ports:
//   clock   - system clock, rising edge
//   reset_n - synchronous active-low reset, clears the remainder
//   clear   - synchronous clear to 0 (takes priority over enable)
//   enable  - shift bit_in into the remainder this cycle
//   bit_in  - message bit, MSB first
//   crc     - current remainder
module crc4_serial
  import fpga_bus_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc
);

  logic [CRC_W-1:0] crc_q;
  logic [CRC_W-1:0] crc_d;
  logic             fb;

  always_comb begin
    crc_d = crc_q;
    fb    = bit_in ^ crc_q[CRC_W-1];
    if (clear) begin
      crc_d = '0;
    end else if (enable) begin
      crc_d = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) crc_q <= '0;
    else          crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/bus_frame_receiver.sv
// Serial bus frame receiver: detects the start bit, deserialises
// src/dst/mod/data/crc (MSB first), checks CRC-4 and filters on mode and
// destination address, then reports one result pulse per frame.
// Optional build macro RX_STATS_EN adds saturating 16-bit statistics
// outputs ok_cnt, crc_err_cnt and drop_cnt.
// Ports:
//   clock, reset_n    - clock and synchronous active-low reset
//   bus_in            - serial bus line (idles low)
//   rx_valid          - one-cycle pulse, frame accepted
//   rx_data/src/mod   - fields of the last accepted frame (held)
//   crc_err, mod_err  - one-cycle error pulses
//   busy              - frame reception in progress
module bus_frame_receiver #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned CRC_W     = 4,
  parameter logic [ADDR_W-1:0] NODE_ADDR = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              bus_in,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic [ADDR_W-1:0] rx_src,
  output logic [1:0]        rx_mod,
  output logic              crc_err,
  output logic              mod_err,
  output logic              busy
`ifdef RX_STATS_EN
  ,
  output logic [15:0]       ok_cnt,
  output logic [15:0]       crc_err_cnt,
  output logic [15:0]       drop_cnt
`endif
);

  import fpga_bus_pkg::*;

  localparam int unsigned HDR_W = 2 * ADDR_W + MOD_W;

  rx_state_e         state_q, state_d;
  logic [6:0]        cnt_q, cnt_d;
  logic [HDR_W-1:0]  hdr_q, hdr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CRC_W-2:0]  cmp_q, cmp_d;
  logic              rx_valid_q, rx_valid_d;
  logic              crc_err_q, crc_err_d;
  logic              mod_err_q, mod_err_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [ADDR_W-1:0] rx_src_q, rx_src_d;
  logic [1:0]        rx_mod_q, rx_mod_d;

  logic              crc_clr;
  logic              crc_en;
  logic [CRC_W-1:0]  crc_rem;

  logic [ADDR_W-1:0] hdr_src;
  logic [ADDR_W-1:0] hdr_dst;
  mod_e              hdr_mod;
  logic              last_bit;
  logic              crc_ok;
  logic              accept;

  crc4_serial u_crc (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (crc_clr),
    .enable  (crc_en),
    .bit_in  (bus_in),
    .crc     (crc_rem)
  );

  assign hdr_src  = hdr_q[HDR_W-1 -: ADDR_W];
  assign hdr_dst  = hdr_q[MOD_W +: ADDR_W];
  assign hdr_mod  = mod_e'(hdr_q[MOD_W-1:0]);
  // The final CRC bit is compared straight off the line, so the decision
  // lands on the same edge that samples it.
  assign last_bit = (state_q == ST_CRC_RX) && (cnt_q == 7'(CRC_W - 1));
  assign crc_ok   = ({cmp_q, bus_in} == crc_rem);
  assign accept   = (hdr_mod == MOD_BCAST) ||
                    ((hdr_mod == MOD_UNICAST) && (hdr_dst == NODE_ADDR));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 7'd1;
    hdr_d      = hdr_q;
    data_d     = data_q;
    cmp_d      = cmp_q;
    rx_valid_d = 1'b0;
    crc_err_d  = 1'b0;
    mod_err_d  = 1'b0;
    rx_data_d  = rx_data_q;
    rx_src_d   = rx_src_q;
    rx_mod_d   = rx_mod_q;
    crc_clr    = 1'b0;
    crc_en     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (bus_in) begin
          state_d = ST_HDR;
          crc_clr = 1'b1;
        end
      end
      ST_HDR: begin
        crc_en = 1'b1;
        hdr_d  = {hdr_q[HDR_W-2:0], bus_in};
        if (cnt_q == 7'(HDR_W - 1)) begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end
      end
      ST_DATA: begin
        crc_en = 1'b1;
        data_d = {data_q[DATA_W-2:0], bus_in};
        if (cnt_q == 7'(DATA_W - 1)) begin
          state_d = ST_CRC_RX;
          cnt_d   = '0;
        end
      end
      ST_CRC_RX: begin
        cmp_d = {cmp_q[CRC_W-3:0], bus_in};
        if (last_bit) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          if (!crc_ok) begin
            crc_err_d = 1'b1;
          end else if (hdr_mod[1]) begin
            mod_err_d = 1'b1;
          end else if (accept) begin
            rx_valid_d = 1'b1;
            rx_data_d  = data_q;
            rx_src_d   = hdr_src;
            rx_mod_d   = hdr_q[MOD_W-1:0];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      hdr_q      <= '0;
      data_q     <= '0;
      cmp_q      <= '0;
      rx_valid_q <= 1'b0;
      crc_err_q  <= 1'b0;
      mod_err_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_src_q   <= '0;
      rx_mod_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hdr_q      <= hdr_d;
      data_q     <= data_d;
      cmp_q      <= cmp_d;
      rx_valid_q <= rx_valid_d;
      crc_err_q  <= crc_err_d;
      mod_err_q  <= mod_err_d;
      rx_data_q  <= rx_data_d;
      rx_src_q   <= rx_src_d;
      rx_mod_q   <= rx_mod_d;
    end
  end

  assign rx_valid = rx_valid_q;
  assign crc_err  = crc_err_q;
  assign mod_err  = mod_err_q;
  assign rx_data  = rx_data_q;
  assign rx_src   = rx_src_q;
  assign rx_mod   = rx_mod_q;
  assign busy     = (state_q != ST_IDLE);

`ifdef RX_STATS_EN
  logic [15:0] ok_cnt_q, ok_cnt_d;
  logic [15:0] crc_err_cnt_q, crc_err_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Drops cover both reserved modes and unicast address misses.
  always_comb begin
    ok_cnt_d      = rx_valid_d ? sat_inc16(ok_cnt_q) : ok_cnt_q;
    crc_err_cnt_d = crc_err_d ? sat_inc16(crc_err_cnt_q) : crc_err_cnt_q;
    drop_cnt_d    = (last_bit && crc_ok && !accept) ? sat_inc16(drop_cnt_q) : drop_cnt_q;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ok_cnt_q      <= '0;
      crc_err_cnt_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      ok_cnt_q      <= ok_cnt_d;
      crc_err_cnt_q <= crc_err_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign ok_cnt      = ok_cnt_q;
  assign crc_err_cnt = crc_err_cnt_q;
  assign drop_cnt    = drop_cnt_q;
`endif

endmodule

// File: tb/tb_bus_frame_receiver.sv
// Bench for bus_frame_receiver: two receivers (node 0 and node 3) share one
// bus line. A per-cycle stimulus schedule and expected-event schedule are
// built up front from frame-level rules, then replayed and compared.
module tb_bus_frame_receiver;

  localparam int MAXC = 4096;

  logic        clock;
  logic        reset_n;
  logic        bus_in;
  logic [1:0]  rxv, cre, mde, bsy;
  logic [63:0] rxd [2];
  logic [3:0]  rxs [2];
  logic [1:0]  rxm [2];
`ifdef RX_STATS_EN
  logic [15:0] okc [2];
  logic [15:0] cec [2];
  logic [15:0] drc [2];
`endif

  bus_frame_receiver #(.DATA_W(64), .ADDR_W(4), .CRC_W(4), .NODE_ADDR(4'h0)) dut0 (
    .clock(clock), .reset_n(reset_n), .bus_in(bus_in),
    .rx_valid(rxv[0]), .rx_data(rxd[0]), .rx_src(rxs[0]), .rx_mod(rxm[0]),
    .crc_err(cre[0]), .mod_err(mde[0]), .busy(bsy[0])
`ifdef RX_STATS_EN
    , .ok_cnt(okc[0]), .crc_err_cnt(cec[0]), .drop_cnt(drc[0])
`endif
  );

  bus_frame_receiver #(.DATA_W(64), .ADDR_W(4), .CRC_W(4), .NODE_ADDR(4'h3)) dut3 (
    .clock(clock), .reset_n(reset_n), .bus_in(bus_in),
    .rx_valid(rxv[1]), .rx_data(rxd[1]), .rx_src(rxs[1]), .rx_mod(rxm[1]),
    .crc_err(cre[1]), .mod_err(mde[1]), .busy(bsy[1])
`ifdef RX_STATS_EN
    , .ok_cnt(okc[1]), .crc_err_cnt(cec[1]), .drop_cnt(drc[1])
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Schedule: line/rstn are driven before posedge t; ev/busy_e/p* describe
  // the DUT state right after posedge t.
  // ev codes: 0 nothing, 1 accepted, 2 crc error, 3 mode error, 4 address drop.
  logic        line   [MAXC];
  logic        rstn   [MAXC];
  logic        busy_e [MAXC];
  logic [2:0]  ev     [2][MAXC];
  logic [63:0] pd     [MAXC];
  logic [3:0]  ps     [MAXC];
  logic [1:0]  pm     [MAXC];
  int          pos;

  int errors = 0;
  int checks = 0;
  int cur_cyc = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cur_cyc, got, exp);
    end
  endtask

  // CRC by polynomial long division of M(x)*x^4 by x^4+x+1.
  function automatic logic [3:0] ref_crc(input logic [3:0] s, input logic [3:0] d,
                                         input logic [1:0] m, input logic [63:0] dat);
    logic [77:0] v;
    v = {s, d, m, dat, 4'h0};
    for (int i = 77; i >= 4; i--)
      if (v[i]) v[i -: 5] = v[i -: 5] ^ 5'b10011;
    return v[3:0];
  endfunction

  task automatic add_frame(input logic [3:0] s, input logic [3:0] d, input logic [1:0] m,
                           input logic [63:0] dat, input logic [3:0] c, input int gap);
    logic [78:0] fr;
    logic        good;
    int          last;
    logic [3:0]  addr;
    fr   = {1'b1, s, d, m, dat, c};
    last = pos + 78;
    for (int k = 0; k < 79; k++) line[pos + k] = fr[78 - k];
    for (int k = 0; k < 78; k++) busy_e[pos + k] = 1'b1;
    good = (c == ref_crc(s, d, m, dat));
    for (int i = 0; i < 2; i++) begin
      addr = (i == 0) ? 4'h0 : 4'h3;
      if (!good)                        ev[i][last] = 3'd2;
      else if (m[1])                    ev[i][last] = 3'd3;
      else if (m == 2'b01 || d == addr) ev[i][last] = 3'd1;
      else                              ev[i][last] = 3'd4;
    end
    pd[last] = dat;
    ps[last] = s;
    pm[last] = m;
    pos = last + 1 + gap;
  endtask

  // Frame cut by reset_n low while bit 40 is on the line.
  task automatic add_cut_frame(input logic [3:0] s, input logic [3:0] d, input logic [1:0] m,
                               input logic [63:0] dat);
    logic [78:0] fr;
    fr = {1'b1, s, d, m, dat, 4'h0};
    for (int k = 0; k <= 40; k++) line[pos + k] = fr[78 - k];
    for (int k = 0; k < 40; k++) busy_e[pos + k] = 1'b1;
    rstn[pos + 40] = 1'b0;
    pos = pos + 43;
  endtask

  logic [63:0] hd [2];
  logic [3:0]  hs [2];
  logic [1:0]  hm [2];
  int          n_ok [2];
  int          n_ce [2];
  int          n_dr [2];

  initial begin
    logic [3:0]  s, d, c;
    logic [1:0]  m;
    logic [63:0] dat;
    reset_n = 1'b0;
    bus_in  = 1'b0;
    for (int t = 0; t < MAXC; t++) begin
      line[t] = 1'b0; rstn[t] = 1'b1; busy_e[t] = 1'b0;
      ev[0][t] = 3'd0; ev[1][t] = 3'd0;
      pd[t] = '0; ps[t] = '0; pm[t] = '0;
    end
    for (int t = 0; t < 3; t++) rstn[t] = 1'b0;
    pos = 4;

    add_frame(4'h0, 4'h0, 2'b00, 64'h0, 4'h0, 2);   // good unicast to node 0
    add_frame(4'h0, 4'h0, 2'b00, 64'h0, 4'h1, 2);   // bad crc
    add_frame(4'h0, 4'h0, 2'b01, 64'h0, 4'h5, 2);   // broadcast
    add_frame(4'h0, 4'h0, 2'b10, 64'h0, 4'hA, 2);   // reserved mode
    add_frame(4'h0, 4'h0, 2'b00, 64'h0, 4'h0, 0);   // back-to-back pair
    add_frame(4'h0, 4'h0, 2'b00, 64'h0, 4'h0, 2);
    add_frame(4'h7, 4'h3, 2'b00, 64'hDEAD_BEEF_0123_4567,
              ref_crc(4'h7, 4'h3, 2'b00, 64'hDEAD_BEEF_0123_4567), 1);
    add_cut_frame(4'h5, 4'h0, 2'b01, 64'hFFFF_0000_FFFF_0000);
    add_frame(4'h9, 4'h0, 2'b00, 64'h1234_5678_9ABC_DEF0,
              ref_crc(4'h9, 4'h0, 2'b00, 64'h1234_5678_9ABC_DEF0), 2);

    for (int f = 0; f < 30 && pos + 90 < MAXC; f++) begin
      s   = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       d = 4'h0;
        1:       d = 4'h3;
        default: d = 4'($urandom_range(0, 15));
      endcase
      m   = 2'($urandom_range(0, 3));
      dat = {$urandom, $urandom};
      c   = ref_crc(s, d, m, dat);
      if ($urandom_range(0, 3) == 0) c = c ^ 4'($urandom_range(1, 15));
      add_frame(s, d, m, dat, c, $urandom_range(0, 3));
    end

    for (int i = 0; i < 2; i++) begin
      hd[i] = '0; hs[i] = '0; hm[i] = '0;
      n_ok[i] = 0; n_ce[i] = 0; n_dr[i] = 0;
    end

    for (int t = 0; t <= pos + 4 && t < MAXC; t++) begin
      @(negedge clock);
      if (t > 0) begin
        cur_cyc = t - 1;
        for (int i = 0; i < 2; i++) begin
          if (!rstn[t-1]) begin
            hd[i] = '0; hs[i] = '0; hm[i] = '0;
            n_ok[i] = 0; n_ce[i] = 0; n_dr[i] = 0;
          end else begin
            case (ev[i][t-1])
              3'd1: begin
                hd[i] = pd[t-1]; hs[i] = ps[t-1]; hm[i] = pm[t-1];
                n_ok[i]++;
              end
              3'd2:    n_ce[i]++;
              3'd3,
              3'd4:    n_dr[i]++;
              default: ;
            endcase
          end
          check_eq($sformatf("valid%0d", i), 64'(rxv[i]), 64'(ev[i][t-1] == 3'd1));
          check_eq($sformatf("crc_err%0d", i), 64'(cre[i]), 64'(ev[i][t-1] == 3'd2));
          check_eq($sformatf("mod_err%0d", i), 64'(mde[i]), 64'(ev[i][t-1] == 3'd3));
          check_eq($sformatf("busy%0d", i), 64'(bsy[i]), 64'(busy_e[t-1]));
          check_eq($sformatf("rx_data%0d", i), rxd[i], hd[i]);
          check_eq($sformatf("rx_src%0d", i), 64'(rxs[i]), 64'(hs[i]));
          check_eq($sformatf("rx_mod%0d", i), 64'(rxm[i]), 64'(hm[i]));
        end
      end
      bus_in  = line[t];
      reset_n = rstn[t];
    end

`ifdef RX_STATS_EN
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("ok_cnt%0d", i), 64'(okc[i]), 64'(n_ok[i]));
      check_eq($sformatf("crc_err_cnt%0d", i), 64'(cec[i]), 64'(n_ce[i]));
      check_eq($sformatf("drop_cnt%0d", i), 64'(drc[i]), 64'(n_dr[i]));
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
